// File: rtl/stage2_decode.sv
// ============================================================================
// Module   : stage2_decode
// Purpose  : RV32I decode stage with a registered output and a one-entry skid
//            buffer on a valid/ready pipe; execute-side flush kills all state.
//            Optional macro DECODE_RV32M_EN decodes OP/funct7=0000001 as MULDIV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage2_decode #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_instruction_i,
    input  logic [WIDTH-1:0] in_program_counter_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_program_counter_o,
    output logic [3:0]       out_op_class_o,
    output logic [4:0]       out_rd_o,
    output logic [4:0]       out_rs1_o,
    output logic [4:0]       out_rs2_o,
    output logic             out_rd_write_o,
    output logic [2:0]       out_funct3_o,
    output logic             out_funct7_b5_o,
    output logic [WIDTH-1:0] out_imm_o
);

    localparam logic [3:0] C_CLS_LUI     = 4'd0;
    localparam logic [3:0] C_CLS_AUIPC   = 4'd1;
    localparam logic [3:0] C_CLS_JAL     = 4'd2;
    localparam logic [3:0] C_CLS_JALR    = 4'd3;
    localparam logic [3:0] C_CLS_BRANCH  = 4'd4;
    localparam logic [3:0] C_CLS_LOAD    = 4'd5;
    localparam logic [3:0] C_CLS_STORE   = 4'd6;
    localparam logic [3:0] C_CLS_OP_IMM  = 4'd7;
    localparam logic [3:0] C_CLS_OP      = 4'd8;
    localparam logic [3:0] C_CLS_FENCE   = 4'd9;
    localparam logic [3:0] C_CLS_SYSTEM  = 4'd10;
    localparam logic [3:0] C_CLS_MULDIV  = 4'd11;
    localparam logic [3:0] C_CLS_ILLEGAL = 4'd15;

    // Opcode bits [6:2]; bits [1:0] must be 2'b11 for any legal word
    localparam logic [4:0] C_OPC_LUI    = 5'b01101;
    localparam logic [4:0] C_OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] C_OPC_JAL    = 5'b11011;
    localparam logic [4:0] C_OPC_JALR   = 5'b11001;
    localparam logic [4:0] C_OPC_BRANCH = 5'b11000;
    localparam logic [4:0] C_OPC_LOAD   = 5'b00000;
    localparam logic [4:0] C_OPC_STORE  = 5'b01000;
    localparam logic [4:0] C_OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] C_OPC_OP     = 5'b01100;
    localparam logic [4:0] C_OPC_FENCE  = 5'b00011;
    localparam logic [4:0] C_OPC_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [3:0]       op_class;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic             rd_write;
        logic [2:0]       funct3;
        logic             funct7_b5;
        logic [WIDTH-1:0] imm;
    } dec_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    dec_t             out_q, out_d;
    dec_t             skid_q;
    dec_t             w_dec;
    logic             w_accept;
    logic             w_out_load;
    logic             w_out_from_skid;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_ins;
    logic [WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_ins = in_instruction_i;

    assign w_imm_i = {{(WIDTH-12){w_ins[31]}}, w_ins[31:20]};
    assign w_imm_s = {{(WIDTH-12){w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
    assign w_imm_b = {{(WIDTH-13){w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25],
                      w_ins[11:8], 1'b0};
    assign w_imm_u = {w_ins[31:12], 12'b0};
    assign w_imm_j = {{(WIDTH-21){w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20],
                      w_ins[30:21], 1'b0};

    // Combinational decode of the word currently offered by fetch
    always_comb begin
        w_dec           = '0;
        w_dec.pc        = in_program_counter_i;
        w_dec.rd        = w_ins[11:7];
        w_dec.rs1       = w_ins[19:15];
        w_dec.rs2       = w_ins[24:20];
        w_dec.funct3    = w_ins[14:12];
        w_dec.funct7_b5 = w_ins[30];
        w_dec.op_class  = C_CLS_ILLEGAL;
        w_dec.imm       = '0;
        if (w_ins[1:0] == 2'b11) begin
            case (w_ins[6:2])
                C_OPC_LUI: begin
                    w_dec.op_class = C_CLS_LUI;
                    w_dec.imm      = w_imm_u;
                end
                C_OPC_AUIPC: begin
                    w_dec.op_class = C_CLS_AUIPC;
                    w_dec.imm      = w_imm_u;
                end
                C_OPC_JAL: begin
                    w_dec.op_class = C_CLS_JAL;
                    w_dec.imm      = w_imm_j;
                end
                C_OPC_JALR: begin
                    if (w_ins[14:12] == 3'b000) begin
                        w_dec.op_class = C_CLS_JALR;
                        w_dec.imm      = w_imm_i;
                    end
                end
                C_OPC_BRANCH: begin
                    w_dec.op_class = C_CLS_BRANCH;
                    w_dec.imm      = w_imm_b;
                end
                C_OPC_LOAD: begin
                    w_dec.op_class = C_CLS_LOAD;
                    w_dec.imm      = w_imm_i;
                end
                C_OPC_STORE: begin
                    w_dec.op_class = C_CLS_STORE;
                    w_dec.imm      = w_imm_s;
                end
                C_OPC_OP_IMM: begin
                    w_dec.op_class = C_CLS_OP_IMM;
                    w_dec.imm      = w_imm_i;
                end
                C_OPC_OP: begin
                    if (w_ins[31:25] == 7'b0000000 || w_ins[31:25] == 7'b0100000) begin
                        w_dec.op_class = C_CLS_OP;
                    end
`ifdef DECODE_RV32M_EN
                    else if (w_ins[31:25] == 7'b0000001) begin
                        w_dec.op_class = C_CLS_MULDIV;
                    end
`endif
                end
                C_OPC_FENCE: begin
                    w_dec.op_class = C_CLS_FENCE;
                    w_dec.imm      = w_imm_i;
                end
                C_OPC_SYSTEM: begin
                    w_dec.op_class = C_CLS_SYSTEM;
                    w_dec.imm      = w_imm_i;
                end
                default: begin
                    w_dec.op_class = C_CLS_ILLEGAL;
                end
            endcase
        end

        case (w_dec.op_class)
            C_CLS_LUI, C_CLS_AUIPC, C_CLS_JAL, C_CLS_JALR,
            C_CLS_LOAD, C_CLS_OP_IMM, C_CLS_OP, C_CLS_MULDIV:
                w_dec.rd_write = (w_ins[11:7] != 5'd0);
            default:
                w_dec.rd_write = 1'b0;
        endcase
    end

    // Ready depends only on reset and skid occupancy so fetch never sees a loop
    assign in_ready_o = !rst && (state_q != S_FULL);
    assign w_accept   = in_valid_i && in_ready_o;

    always_comb begin
        state_d         = state_q;
        w_out_load      = 1'b0;
        w_out_from_skid = 1'b0;
        w_skid_load     = 1'b0;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (w_accept) begin
                        state_d    = S_ONE;
                        w_out_load = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && out_ready_i) begin
                        w_out_load = 1'b1;
                    end else if (w_accept) begin
                        state_d     = S_FULL;
                        w_skid_load = 1'b1;
                    end else if (out_ready_i) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready_i) begin
                        state_d         = S_ONE;
                        w_out_load      = 1'b1;
                        w_out_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
        out_d = w_out_from_skid ? skid_q : w_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (w_out_load) begin
                out_q <= out_d;
            end
            if (w_skid_load) begin
                skid_q <= w_dec;
            end
        end
    end

    assign out_valid_o           = (state_q != S_EMPTY);
    assign out_program_counter_o = out_q.pc;
    assign out_op_class_o        = out_q.op_class;
    assign out_rd_o              = out_q.rd;
    assign out_rs1_o             = out_q.rs1;
    assign out_rs2_o             = out_q.rs2;
    assign out_rd_write_o        = out_q.rd_write;
    assign out_funct3_o          = out_q.funct3;
    assign out_funct7_b5_o       = out_q.funct7_b5;
    assign out_imm_o             = out_q.imm;

endmodule

`default_nettype wire

// File: tb/tb_stage2_decode.sv
// ============================================================================
// Module   : tb_stage2_decode
// Purpose  : Directed self-checking bench for stage2_decode (decode table,
//            skid buffer, flush, reset). Honours DECODE_RV32M_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage2_decode;

    localparam int WIDTH = 32;
    localparam int NVEC  = 15;

`ifdef DECODE_RV32M_EN
    localparam logic [3:0] C_MUL_CLS = 4'd11;
    localparam logic       C_MUL_RDW = 1'b1;
`else
    localparam logic [3:0] C_MUL_CLS = 4'd15;
    localparam logic       C_MUL_RDW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_instruction_i = '0;
    logic [WIDTH-1:0] in_program_counter_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] out_program_counter_o;
    logic [3:0]       out_op_class_o;
    logic [4:0]       out_rd_o, out_rs1_o, out_rs2_o;
    logic             out_rd_write_o;
    logic [2:0]       out_funct3_o;
    logic             out_funct7_b5_o;
    logic [WIDTH-1:0] out_imm_o;

    int checks   = 0;
    int failures = 0;

    // Hand-decoded vector table: fields = {rd, rs1, rs2, funct3, funct7_b5}
    logic [31:0] v_ins  [NVEC] = '{32'h00500093, 32'hFE000EE3, 32'h0000006F, 32'h123452B7,
                                   32'h0020A423, 32'h402081B3, 32'h000010E7, 32'h00500091,
                                   32'h02208033, 32'h00000000, 32'h04208033, 32'h022080B3,
                                   32'hFFF00113, 32'h008000EF, 32'hFF812283};
    logic [3:0]  v_cls  [NVEC] = '{4'd7, 4'd4, 4'd2, 4'd0, 4'd6, 4'd8, 4'd15, 4'd15,
                                   C_MUL_CLS, 4'd15, 4'd15, C_MUL_CLS, 4'd7, 4'd2, 4'd5};
    logic        v_rdw  [NVEC] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, C_MUL_RDW, 1'b1, 1'b1, 1'b1};
    logic [31:0] v_imm  [NVEC] = '{32'h00000005, 32'hFFFFFFFC, 32'h0, 32'h12345000,
                                   32'h00000008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFF8};
    logic [18:0] v_fld  [NVEC] = '{{5'd1, 5'd0, 5'd5, 3'd0, 1'b0},
                                   {5'd29, 5'd0, 5'd0, 3'd0, 1'b1},
                                   {5'd0, 5'd0, 5'd0, 3'd0, 1'b0},
                                   {5'd5, 5'd8, 5'd3, 3'd5, 1'b0},
                                   {5'd8, 5'd1, 5'd2, 3'd2, 1'b0},
                                   {5'd3, 5'd1, 5'd2, 3'd0, 1'b1},
                                   {5'd1, 5'd0, 5'd0, 3'd1, 1'b0},
                                   {5'd1, 5'd0, 5'd5, 3'd0, 1'b0},
                                   {5'd0, 5'd1, 5'd2, 3'd0, 1'b0},
                                   {5'd0, 5'd0, 5'd0, 3'd0, 1'b0},
                                   {5'd0, 5'd1, 5'd2, 3'd0, 1'b0},
                                   {5'd1, 5'd1, 5'd2, 3'd0, 1'b0},
                                   {5'd2, 5'd0, 5'd31, 3'd0, 1'b1},
                                   {5'd1, 5'd0, 5'd8, 3'd0, 1'b0},
                                   {5'd5, 5'd2, 5'd24, 3'd2, 1'b1}};

    stage2_decode #(.WIDTH(WIDTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush_i               (flush_i),
        .in_valid_i            (in_valid_i),
        .in_ready_o            (in_ready_o),
        .in_instruction_i      (in_instruction_i),
        .in_program_counter_i  (in_program_counter_i),
        .out_valid_o           (out_valid_o),
        .out_ready_i           (out_ready_i),
        .out_program_counter_o (out_program_counter_o),
        .out_op_class_o        (out_op_class_o),
        .out_rd_o              (out_rd_o),
        .out_rs1_o             (out_rs1_o),
        .out_rs2_o             (out_rs2_o),
        .out_rd_write_o        (out_rd_write_o),
        .out_funct3_o          (out_funct3_o),
        .out_funct7_b5_o       (out_funct7_b5_o),
        .out_imm_o             (out_imm_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o);
        end
        checks++;
        if (in_ready_o !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_o);
        end
        checks++;
        if ({out_program_counter_o, out_imm_o} !== 64'h0) begin
            failures++; $display("FAIL reset_data got pc=%h imm=%h exp 0", out_program_counter_o, out_imm_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready_o);
        end
    endtask

    // Streams the whole table back-to-back with out_ready held high
    task automatic test_decode;
        out_ready_i = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            in_valid_i           = 1'b1;
            in_instruction_i     = v_ins[i];
            in_program_counter_i = 32'h1000 + 32'(i * 4);
            tick();
            checks++;
            if (out_valid_o !== 1'b1 || out_program_counter_o !== 32'h1000 + 32'(i * 4)) begin
                failures++;
                $display("FAIL dec_valid_pc[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid_o,
                         out_program_counter_o, 32'h1000 + 32'(i * 4));
            end
            checks++;
            if (out_op_class_o !== v_cls[i]) begin
                failures++; $display("FAIL dec_class[%0d] got=%0d exp=%0d", i, out_op_class_o, v_cls[i]);
            end
            checks++;
            if (out_imm_o !== v_imm[i]) begin
                failures++; $display("FAIL dec_imm[%0d] got=%h exp=%h", i, out_imm_o, v_imm[i]);
            end
            checks++;
            if (out_rd_write_o !== v_rdw[i]) begin
                failures++; $display("FAIL dec_rd_write[%0d] got=%b exp=%b", i, out_rd_write_o, v_rdw[i]);
            end
            checks++;
            if ({out_rd_o, out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_b5_o} !== v_fld[i]) begin
                failures++;
                $display("FAIL dec_fields[%0d] got rd=%0d rs1=%0d rs2=%0d f3=%0d f7b5=%b exp=%h", i,
                         out_rd_o, out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_b5_o, v_fld[i]);
            end
        end
        in_valid_i = 1'b0;
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++; $display("FAIL dec_drain got=%b exp=0", out_valid_o);
        end
    endtask

    task automatic test_skid;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_instruction_i = 32'h00100093; in_program_counter_i = 32'h200;
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_program_counter_o !== 32'h200 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL skid_one got v=%b pc=%h rdy=%b exp 1/200/1", out_valid_o, out_program_counter_o, in_ready_o);
        end
        in_instruction_i = 32'h00200113; in_program_counter_i = 32'h204;
        tick();
        checks++;
        if (in_ready_o !== 1'b0 || out_program_counter_o !== 32'h200) begin
            failures++; $display("FAIL skid_full got rdy=%b pc=%h exp 0/200", in_ready_o, out_program_counter_o);
        end
        in_instruction_i = 32'h00300193; in_program_counter_i = 32'h208;
        tick();
        checks++;
        if (in_ready_o !== 1'b0 || out_program_counter_o !== 32'h200 || out_imm_o !== 32'h1) begin
            failures++; $display("FAIL skid_hold got rdy=%b pc=%h imm=%h exp 0/200/1", in_ready_o, out_program_counter_o, out_imm_o);
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_program_counter_o !== 32'h204 || out_imm_o !== 32'h2 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL skid_release got v=%b pc=%h imm=%h rdy=%b exp 1/204/2/1", out_valid_o,
                                 out_program_counter_o, out_imm_o, in_ready_o);
        end
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++; $display("FAIL skid_empty got v=%b pc=%h exp v=0", out_valid_o, out_program_counter_o);
        end
    endtask

    task automatic test_flush;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_instruction_i = 32'h00100093; in_program_counter_i = 32'h300;
        tick();
        in_program_counter_i = 32'h304;
        tick();
        flush_i = 1'b1; in_program_counter_i = 32'h308;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL flush_full got v=%b rdy=%b exp 0/1", out_valid_o, in_ready_o);
        end
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_stays_empty got v=%b pc=%h exp v=0", out_valid_o, out_program_counter_o);
        end
        // Flush in ONE while a word is genuinely accepted
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_program_counter_i = 32'h500;
        tick();
        flush_i = 1'b1; in_program_counter_i = 32'h504;
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_accept got v=%b pc=%h exp v=0", out_valid_o, out_program_counter_o);
        end
        flush_i = 1'b0; out_ready_i = 1'b1;
        in_instruction_i = 32'h00700093; in_program_counter_i = 32'h400;
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_program_counter_o !== 32'h400 || out_imm_o !== 32'h7) begin
            failures++; $display("FAIL flush_resume got v=%b pc=%h imm=%h exp 1/400/7", out_valid_o, out_program_counter_o, out_imm_o);
        end
        in_valid_i = 1'b0;
        tick();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_no_ghost got v=%b pc=%h exp v=0", out_valid_o, out_program_counter_o);
        end
    endtask

    task automatic test_reset_midop;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_instruction_i = 32'hFFF00113; in_program_counter_i = 32'h600;
        tick();
        checks++;
        if (out_valid_o !== 1'b1 || out_imm_o !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL midrst_pre got v=%b imm=%h exp 1/ffffffff", out_valid_o, out_imm_o);
        end
        in_valid_i = 1'b0; rst = 1'b1;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || out_imm_o !== 32'h0 || out_program_counter_o !== 32'h0 || in_ready_o !== 1'b0) begin
            failures++; $display("FAIL midrst got v=%b imm=%h pc=%h rdy=%b exp 0/0/0/0", out_valid_o, out_imm_o,
                                 out_program_counter_o, in_ready_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++; $display("FAIL midrst_after got v=%b rdy=%b exp 0/1", out_valid_o, in_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_skid();
        test_flush();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stage2_decode.md
# stage2_decode

RV32I decode stage sitting directly downstream of the fetch stage and upstream of execute. It accepts fetched instruction/PC pairs over a valid/ready handshake, decodes each into operation class, register indices, write-enable and a sign-extended immediate, and presents the result from a registered output backed by a one-entry skid buffer. A branch-taken flush from execute discards all in-flight decode state in one cycle.

## Interface
- WIDTH, 32, data and PC width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  branch taken in execute; kill all held and incoming instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  decode can accept this cycle.
- in_instruction  in  WIDTH  raw instruction word.
- in_program_counter  in  WIDTH  PC of in_instruction.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute consumes this cycle.
- out_program_counter  out  WIDTH  PC, passed through unchanged.
- out_op_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 11 MULDIV, 15 ILLEGAL.
- out_rd, out_rs1, out_rs2  out  5 each  register indices from bits [11:7], [19:15], [24:20].
- out_rd_write  out  1  writes rd; 0 for BRANCH, STORE, FENCE, SYSTEM, ILLEGAL, and whenever rd==0.
- out_funct3  out  3  bits [14:12].
- out_funct7_b5  out  1  bit 30.
- out_imm  out  WIDTH  sign-extended immediate (I/S/B/U/J per class; 0 for OP, MULDIV, ILLEGAL).

## Operation
- Decode is combinational on the accepted word; result captured into output register (OUT) or skid register (SKID).
- Accept = in_valid && in_ready.
- State: EMPTY (OUT, SKID invalid), ONE (OUT valid), FULL (OUT and SKID valid).
- EMPTY: accept -> ONE.
- ONE: accept && out_ready -> ONE (OUT replaced); accept && !out_ready -> FULL (new word into SKID); !accept && out_ready -> EMPTY.
- FULL: out_ready -> ONE (SKID moves to OUT, SKID cleared); otherwise hold. in_ready=0 in FULL.
- Illegal: bits [1:0] != 2'b11, unknown opcode, OP with funct7 not in {0000000, 0100000} (plus 0000001 when M enabled), JALR with funct3 != 0. Illegal words are still passed downstream with class 15; decode never stalls on them.
- Immediates: I = {20{b31}, b31:20}; S = {20{b31}, b31:25, b11:7}; B = {19{b31}, b31, b7, b30:25, b11:8, 0}; U = {b31:12, 12'b0}; J = {11{b31}, b31, b19:12, b20, b30:21, 0}.

## Timing
- Latency: accept at edge N -> out_valid high after edge N, fields stable until out_valid && out_ready.
- Throughput: one instruction per cycle when out_ready stays high.
- in_ready = !rst && !SKID valid (combinational from state only, never from in_valid).
- Reset: out_valid=0, SKID invalid, all data outputs 0, in_ready=0 during rst, 1 the cycle after.
- Flush: at the edge where flush=1, OUT and SKID invalidated; any word accepted in that cycle discarded; out_valid=0 next cycle. Flush has priority over accept and out_ready.
- rst has priority over flush. Reset mid-operation drops everything identically.
- Data registers load only on capture; no change while holding.

## Configuration
- DECODE_RV32M_EN defined: OP with funct7=0000001 decodes as class 11 MULDIV, rd_write per rd rule, imm=0.
- Not defined: those encodings decode as class 15 ILLEGAL, rd_write=0.

## Test plan
- Reset then in_valid with 0x00500093 (addi x1,x0,5), PC 0x0 -> next cycle out_valid=1, class 7, rd=1, rs1=0, imm=0x00000005, rd_write=1.
- Stream 0xFE000EE3 (beq x0,x0,-4) -> class 4, imm=0xFFFFFFFC, rd_write=0; 0x0000006F (jal x0,0) -> class 2, rd_write=0 (rd==0).
- out_ready=0 for 3 cycles while in_valid=1 -> one word in OUT, one in SKID, in_ready=0; release out_ready -> both delivered in order on consecutive cycles, no loss or duplicate.
- In FULL state assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed words never appear.
- 0x02208033 (mul x0,x1,x2) -> class 11 with DECODE_RV32M_EN, class 15 without; 0x00000000 -> class 15 in both.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_imm=0, out_program_counter=0.
